// File: rtl/rvcpu_pkg.sv
// Shared types for the rvcpu memory stage: memory op codes, MEM/WB payload, and the MEM FSM state.
package rvcpu;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LH   = 4'd2,
    LW   = 4'd3,
    LBU  = 4'd4,
    LHU  = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_valid;
    logic [31:0] rd_data;
  } stage_mem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_load(input mem_op_t op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

endpackage

// File: rtl/lsu_format.sv
// Combinational lane handling for the memory stage: store byte enables and data
// replication, load byte/half extraction with sign or zero extension.
module lsu_format
  import rvcpu::*;
(
  input  mem_op_t     mem_op,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (mem_op)
      SB: begin
        be    = 4'b0001 << lane;
        wdata = {4{store_data[7:0]}};
      end
      SH: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = load_word[{lane, 3'b000} +: 8];
    ld_half   = lane[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    case (mem_op)
      LB:      load_data = {{24{ld_byte[7]}}, ld_byte};
      LBU:     load_data = {24'd0, ld_byte};
      LH:      load_data = {{16{ld_half[15]}}, ld_half};
      LHU:     load_data = {16'd0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: handshakes with data memory via a 4-state FSM and formats results.
// Optional macro RVCPU_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of issuing them.
module stage_mem
  import rvcpu::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  rd_i,
  input  logic        rd_valid_i,
  input  logic [31:0] res_i,
  input  logic [31:0] store_data_i,
  input  mem_op_t     mem_op_i,
  output stage_mem_t  out,
  output logic        stallreq_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        misalign
);

  mem_state_t  state, state_nx;
  logic [31:0] rdata_q;
  logic        mem_act;
  logic        misalign_hit;
  logic        req_c, stall_c, capture_c, trap_c;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_load;

  assign mem_act = valid_i && (mem_op_i != NONE);

`ifdef RVCPU_MISALIGN_TRAP_EN
  assign misalign_hit = mem_act &&
    ((((mem_op_i == LH) || (mem_op_i == LHU) || (mem_op_i == SH)) && res_i[0]) ||
     (((mem_op_i == LW) || (mem_op_i == SW)) && (res_i[1:0] != 2'b00)));
`else
  assign misalign_hit = 1'b0;
`endif

  lsu_format u_fmt (
    .mem_op     (mem_op_i),
    .lane       (res_i[1:0]),
    .store_data (store_data_i),
    .load_word  (rdata_q),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .load_data  (fmt_load)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (capture_c) rdata_q <= dmem_rdata;
    end
  end

  always_comb begin
    state_nx  = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    capture_c = 1'b0;
    trap_c    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_act) begin
          if (misalign_hit) begin
            trap_c = 1'b1;
          end else begin
            req_c    = 1'b1;
            stall_c  = 1'b1;
            state_nx = dmem_gnt ? WAIT : REQ;
          end
        end
      end
      REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dmem_gnt) state_nx = WAIT;
      end
      WAIT: begin
        stall_c = 1'b1;
        if (dmem_rvalid) begin
          capture_c = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address/data are combinational from the EX/MEM inputs, which the stall holds steady during REQ.
  assign dmem_req     = rst && req_c;
  assign dmem_we      = rst && req_c && is_store(mem_op_i);
  assign dmem_addr    = {res_i[31:2], 2'b00};
  assign dmem_be      = fmt_be;
  assign dmem_wdata   = fmt_wdata;
  assign stallreq_mem = rst && stall_c;
  assign misalign     = rst && trap_c;

  always_comb begin
    out = '0;
    if (rst) begin
      out.pc       = pc_i;
      out.rd       = rd_i;
      out.rd_valid = rd_valid_i && !(mem_act && is_store(mem_op_i)) && !trap_c;
      out.rd_data  = ((state == DONE) && is_load(mem_op_i)) ? fmt_load : res_i;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Randomized self-checking bench for stage_mem against a cycle-timeline reference model.
module tb_stage_mem;
  import rvcpu::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [4:0]  rd_i;
  logic        rd_valid_i;
  logic [31:0] res_i;
  logic [31:0] store_data_i;
  mem_op_t     mem_op_i;
  stage_mem_t  out;
  logic        stallreq_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stage_mem dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .pc_i         (pc_i),
    .rd_i         (rd_i),
    .rd_valid_i   (rd_valid_i),
    .res_i        (res_i),
    .store_data_i (store_data_i),
    .mem_op_i     (mem_op_i),
    .out          (out),
    .stallreq_mem (stallreq_mem),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .misalign     (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input mem_op_t op, input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * addr[1:0])) & 32'hFF;
    h = (w >> ((addr[1:0] >= 2) ? 16 : 0)) & 32'hFFFF;
    case (op)
      LB:      return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      LHU:     return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input mem_op_t op, input logic [31:0] addr);
    case (op)
      SB:      return 4'b0001 << addr[1:0];
      SH:      return (addr[1:0] >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input mem_op_t op, input logic [31:0] d);
    case (op)
      SB:      return (d & 32'hFF) * 32'h0101_0101;
      SH:      return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic ref_misaligned(input mem_op_t op, input logic [31:0] addr);
`ifdef RVCPU_MISALIGN_TRAP_EN
    if ((op == LH || op == LHU || op == SH) && (addr % 2 != 0)) return 1'b1;
    if ((op == LW || op == SW) && (addr % 4 != 0)) return 1'b1;
`endif
    return (op == NONE) && (addr != addr);
  endfunction

  // One instruction through the stage: gd cycles before grant, rv_dly cycles between grant and rvalid.
  task automatic run_txn(input mem_op_t op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int gd, input int rv_dly);
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rdv;
    logic        st;
    int          last_wait;
    pc  = $urandom;
    rd  = 5'($urandom_range(0, 31));
    rdv = 1'($urandom_range(0, 1)) | (op == NONE);
    st  = (op == SB) || (op == SH) || (op == SW);
    @(negedge clk);
    valid_i = 1'b1; pc_i = pc; rd_i = rd; rd_valid_i = rdv; res_i = addr;
    store_data_i = sdata; mem_op_i = op; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (op == NONE) begin
      #1;
      check("alu_stall", 32'(stallreq_mem), 0);
      check("alu_req", 32'(dmem_req), 0);
      check("alu_data", out.rd_data, addr);
      check("alu_rdv", 32'(out.rd_valid), 32'(rdv));
      check("alu_pc", out.pc, pc);
      return;
    end
    if (ref_misaligned(op, addr)) begin
      #1;
      check("mis_flag", 32'(misalign), 1);
      check("mis_req", 32'(dmem_req), 0);
      check("mis_stall", 32'(stallreq_mem), 0);
      check("mis_rdv", 32'(out.rd_valid), 0);
      return;
    end
    last_wait = gd + 1 + rv_dly;
    for (int c = 0; c <= last_wait + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c <= gd) begin
        dmem_gnt    = (c == gd);
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        #1;
        check("req_req", 32'(dmem_req), 1);
        check("req_stall", 32'(stallreq_mem), 1);
        check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("req_we", 32'(dmem_we), 32'(st));
        check("req_mis", 32'(misalign), 0);
        if (st) begin
          check("req_be", 32'(dmem_be), 32'(ref_be(op, addr)));
          check("req_wdata", dmem_wdata, ref_wdata(op, sdata));
        end
      end else if (c <= last_wait) begin
        dmem_gnt    = 1'($urandom_range(0, 1));
        dmem_rvalid = (c == last_wait);
        dmem_rdata  = (c == last_wait) ? rdata : $urandom;
        #1;
        check("wait_req", 32'(dmem_req), 0);
        check("wait_stall", 32'(stallreq_mem), 1);
      end else begin
        dmem_gnt    = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        #1;
        check("done_stall", 32'(stallreq_mem), 0);
        check("done_req", 32'(dmem_req), 0);
        check("done_data", out.rd_data, st ? addr : ref_load(op, addr, rdata));
        check("done_rdv", 32'(out.rd_valid), st ? 0 : 32'(rdv));
        check("done_rd", 32'(out.rd), 32'(rd));
      end
    end
  endtask

  task automatic idle_cycle();
    logic [31:0] r;
    logic        rdv;
    r   = $urandom;
    rdv = 1'($urandom_range(0, 1));
    @(negedge clk);
    valid_i = 1'b0; res_i = r; rd_valid_i = rdv;
    mem_op_i = mem_op_t'($urandom_range(1, 8));
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check("bub_stall", 32'(stallreq_mem), 0);
    check("bub_req", 32'(dmem_req), 0);
    check("bub_data", out.rd_data, r);
    check("bub_rdv", 32'(out.rd_valid), 32'(rdv));
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b1; pc_i = 32'h4; rd_i = 5'd3; rd_valid_i = 1'b1;
    res_i = 32'h1234; store_data_i = '0; mem_op_i = LW;
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stallreq_mem), 0);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_mis", 32'(misalign), 0);
    check("rst_pc", out.pc, 0);
    check("rst_data", out.rd_data, 0);
    check("rst_rd", {26'd0, out.rd, out.rd_valid}, 0);
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; dmem_gnt = 1'b0;

    run_txn(NONE, 32'h0000_1234, 32'h0, 32'h0, 0, 0);
    run_txn(LB,   32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0);
    run_txn(SH,   32'h0000_0202, 32'h0000_ABCD, 32'h0, 2, 0);
    run_txn(LHU,  32'h0000_0006, 32'h0, 32'h8001_0000, 0, 1);
    run_txn(LW,   32'h0000_0101, 32'h0, 32'hCAFE_F00D, 1, 0);
    run_txn(SW,   32'h0000_0403, 32'h1357_9BDF, 32'h0, 0, 2);

    // reset while waiting for rvalid, then a late rvalid
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = LW; res_i = 32'h0000_0040; dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
    #1 check("rw_req", 32'(dmem_req), 1);
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1 check("rw_wait", 32'(stallreq_mem), 1);
    rst = 1'b0;
    #1;
    check("rw_rst_stall", 32'(stallreq_mem), 0);
    check("rw_rst_data", out.rd_data, 0);
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rw_late_stall", 32'(stallreq_mem), 0);
    check("rw_late_req", 32'(dmem_req), 0);
    run_txn(LBU, 32'h0000_0041, 32'h0, 32'h0000_7F00, 0, 0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      run_txn(mem_op_t'($urandom_range(0, 8)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 valid_i  in  1  EX/MEM register holds a live instruction.
REQ-004 pc_i  in  32  instruction PC, passed through.
REQ-005 rd_i / rd_valid_i  in  5 / 1  destination register and write-enable, passed through.
REQ-006 res_i  in  32  ALU result; effective address for memory ops.
REQ-007 store_data_i  in  32  rs2 value for stores.
REQ-008 mem_op_i  in  4  rvcpu::mem_op_t: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-009 out  out  rvcpu::stage_mem_t  {pc, rd, rd_valid, rd_data} to the MEM/WB register.
REQ-010 stallreq_mem  out  1  stall request to control.
REQ-011 dmem_req / dmem_we  out  1 / 1  request strobe, write enable.
REQ-012 dmem_addr  out  32  word-aligned address (res_i with [1:0] zeroed).
REQ-013 dmem_be / dmem_wdata  out  4 / 32  byte enables, lane-shifted store data.
REQ-014 dmem_gnt / dmem_rvalid  in  1 / 1  request accepted; response (load data or store acknowledge).
REQ-015 dmem_rdata  in  32  load word.
REQ-016 misalign  out  1  misaligned-access flag (see Configuration).

Function
REQ-017 Non-memory op (mem_op_i==NONE or valid_i==0): out = {pc_i, rd_i, rd_valid_i, res_i} combinationally, stallreq_mem=0, dmem_req=0.
REQ-018 FSM states IDLE, REQ, WAIT, DONE.
REQ-019 IDLE with a memory op: dmem_req=1, stallreq_mem=1; dmem_gnt=1 -> WAIT, otherwise -> REQ.
REQ-020 REQ: dmem_req=1 and all dmem_* outputs held stable until dmem_gnt; gnt -> WAIT.
REQ-021 WAIT: dmem_req=0, stallreq_mem=1; dmem_rvalid -> capture dmem_rdata into a 32-bit register, -> DONE.
REQ-022 DONE: stallreq_mem=0, no new request; out.rd_data = formatted captured data (loads) or res_i (stores); next state IDLE.
REQ-023 Minimum memory-op latency is 3 cycles (IDLE, WAIT, DONE) with same-cycle gnt and next-cycle rvalid.
REQ-024 Byte lane = res_i[1:0]. SB: be=0001<<lane, data replicated ×4. SH: be=0011<<(lane[1]*2), data replicated ×2. SW: be=1111.
REQ-025 Load format: select the byte or half at the lane; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits; LW returns the word unchanged.
REQ-026 Stores force out.rd_valid=0.
REQ-027 dmem_rvalid outside WAIT and dmem_gnt outside IDLE/REQ are ignored.

Reset
REQ-028 rst==0 at a clock edge: state=IDLE and the capture register is cleared to 0.
REQ-029 While rst==0: dmem_req=0, stallreq_mem=0, misalign=0, out=0.
REQ-030 Reset during REQ or WAIT abandons the transaction, and a late rvalid is dropped.

Configuration
REQ-031 Macro RVCPU_MISALIGN_TRAP_EN.
REQ-032 Defined: LH/LHU/SH with res_i[0]=1, or LW/SW with res_i[1:0]!=0, issues no request, asserts misalign for one cycle, and forces out.rd_valid=0 and stallreq_mem=0.
REQ-033 Undefined: misalign is tied to 0 and the low address bits beyond the lane selection are ignored; the access proceeds as if aligned down.

Structure
REQ-034 rvcpu package holds mem_op_t, stage_mem_t, and the FSM state enum mem_state_t.
REQ-035 One sub-module, lsu_format: combinational store lane shifting and load extraction/extension; the FSM stays in stage_mem.

Verification
REQ-036 ADD result 0x0000_1234, mem_op NONE -> same-cycle out.rd_data=0x0000_1234, stallreq_mem=0, no dmem_req.
REQ-037 LB at addr 0x103, rdata 0x80FF_0000 with gnt same cycle and rvalid 1 cycle later -> DONE in cycle 3, rd_data=0xFFFF_FF80.
REQ-038 SH at 0x202, data 0x0000_ABCD, gnt delayed 2 cycles -> req and outputs stable for 3 cycles, be=1100, wdata=0xABCD_ABCD, out.rd_valid=0.
REQ-039 LHU at 0x006, rdata 0x8001_0000 -> rd_data=0x0000_8001.
REQ-040 rst low asserted while in WAIT, then rvalid pulsed -> IDLE, no capture, stallreq_mem=0.
REQ-041 With RVCPU_MISALIGN_TRAP_EN defined: LW at 0x101 -> misalign=1, dmem_req never asserted, rd_valid=0.
